// File: rtl/wall_clock_core.sv
// rtl/wall_clock_core.sv - self-timed time-of-day counter with 12/24 h display and BCD outputs
//
// Purpose:
//   Generates a 1 Hz tick from CLK100MHZ through a prescaler and keeps
//   hours/minutes/seconds. Button pulses set the time, enable pauses it,
//   mode_12h selects the hour display format. Binary and BCD outputs are
//   registered together so they are always coherent.
//
// Ports:
//   CLK100MHZ  in   system clock, rising edge
//   reset      in   synchronous active-high reset, highest priority
//   enable     in   1 = time runs, 0 = prescaler and counters hold
//   mode_12h   in   0 = 24 h display, 1 = 12 h display
//   inc_min    in   single-cycle pulse, minutes+1 mod 60 (no carry), clears seconds
//   inc_hour   in   single-cycle pulse, hour+1 mod 24, clears seconds
//   seconds    out  0..59
//   minutes    out  0..59
//   hours      out  displayed hour, 0..23 or 1..12
//   pm         out  internal hour >= 12
//   sec_bcd    out  seconds as BCD {tens, units}
//   min_bcd    out  minutes as BCD
//   hour_bcd   out  displayed hour as BCD
//   sec_tick   out  one-cycle pulse when a tick advanced the time
//   day_pulse  out  one-cycle pulse on the tick that reaches 00:00:00

module wall_clock_core #(
  parameter int TICKS_PER_SEC = 100000000,
  parameter int CNT_W         = 27
) (
  input  logic       CLK100MHZ,
  input  logic       reset,
  input  logic       enable,
  input  logic       mode_12h,
  input  logic       inc_min,
  input  logic       inc_hour,
  output logic [5:0] seconds,
  output logic [5:0] minutes,
  output logic [4:0] hours,
  output logic       pm,
  output logic [7:0] sec_bcd,
  output logic [7:0] min_bcd,
  output logic [7:0] hour_bcd,
  output logic       sec_tick,
  output logic       day_pulse
);

  localparam logic [CNT_W-1:0] PRESC_LAST = CNT_W'(TICKS_PER_SEC - 1);

  logic [CNT_W-1:0] presc;
  logic [CNT_W-1:0] presc_nxt;
  logic [4:0]       hour;
  logic [4:0]       hour_nxt;
  logic [5:0]       sec_nxt;
  logic [5:0]       min_nxt;
  logic [4:0]       hour_disp;
  logic             inc_any;
  logic             tick;
  logic             sec_wrap;
  logic             min_wrap;
  logic             hour_wrap;

  // Binary 0..59 to packed BCD; a compare chain keeps this shallow and
  // avoids a generic divider.
  function automatic logic [7:0] to_bcd(input logic [5:0] v);
    if (v >= 6'd50)      return {4'd5, 4'(v - 6'd50)};
    else if (v >= 6'd40) return {4'd4, 4'(v - 6'd40)};
    else if (v >= 6'd30) return {4'd3, 4'(v - 6'd30)};
    else if (v >= 6'd20) return {4'd2, 4'(v - 6'd20)};
    else if (v >= 6'd10) return {4'd1, 4'(v - 6'd10)};
    else                 return {4'd0, 4'(v)};
  endfunction

  // Internal 0..23 hour to displayed hour.
  function automatic logic [4:0] disp_hour(input logic [4:0] h, input logic m12);
    if (!m12)            return h;
    else if (h == 5'd0)  return 5'd12;
    else if (h > 5'd12)  return h - 5'd12;
    else                 return h;
  endfunction

  always_comb begin
    inc_any   = inc_min | inc_hour;
    sec_wrap  = (seconds == 6'd59);
    min_wrap  = (minutes == 6'd59);
    hour_wrap = (hour == 5'd23);
    // A set action in the same cycle wins over the terminal count.
    tick      = enable && (presc == PRESC_LAST) && !inc_any;

    presc_nxt = presc;
    sec_nxt   = seconds;
    min_nxt   = minutes;
    hour_nxt  = hour;

    if (inc_any) begin
      presc_nxt = '0;
      sec_nxt   = 6'd0;
      if (inc_min)
        min_nxt = min_wrap ? 6'd0 : minutes + 6'd1;
      if (inc_hour)
        hour_nxt = hour_wrap ? 5'd0 : hour + 5'd1;
    end else if (enable) begin
      if (presc == PRESC_LAST) begin
        presc_nxt = '0;
        sec_nxt   = sec_wrap ? 6'd0 : seconds + 6'd1;
        if (sec_wrap) begin
          min_nxt = min_wrap ? 6'd0 : minutes + 6'd1;
          if (min_wrap)
            hour_nxt = hour_wrap ? 5'd0 : hour + 5'd1;
        end
      end else begin
        presc_nxt = presc + 1'b1;
      end
    end

    hour_disp = disp_hour(hour_nxt, mode_12h);
  end

  // Display outputs are derived from next-state so they appear on the same
  // edge as the counter update, with no extra pipeline stage.
  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      presc     <= '0;
      seconds   <= 6'd0;
      minutes   <= 6'd0;
      hour      <= 5'd0;
      hours     <= mode_12h ? 5'd12 : 5'd0;
      pm        <= 1'b0;
      sec_bcd   <= 8'h00;
      min_bcd   <= 8'h00;
      hour_bcd  <= mode_12h ? 8'h12 : 8'h00;
      sec_tick  <= 1'b0;
      day_pulse <= 1'b0;
    end else begin
      presc     <= presc_nxt;
      seconds   <= sec_nxt;
      minutes   <= min_nxt;
      hour      <= hour_nxt;
      hours     <= hour_disp;
      pm        <= (hour_nxt >= 5'd12);
      sec_bcd   <= to_bcd(sec_nxt);
      min_bcd   <= to_bcd(min_nxt);
      hour_bcd  <= to_bcd({1'b0, hour_disp});
      sec_tick  <= tick;
      day_pulse <= tick && sec_wrap && min_wrap && hour_wrap;
    end
  end

endmodule

// File: tb/tb_wall_clock_core.sv
// tb/tb_wall_clock_core.sv - scoreboard bench for wall_clock_core

module tb_wall_clock_core;

  localparam int T = 4;

  logic       CLK100MHZ = 1'b0;
  logic       reset     = 1'b1;
  logic       enable    = 1'b0;
  logic       mode_12h  = 1'b0;
  logic       inc_min   = 1'b0;
  logic       inc_hour  = 1'b0;
  logic [5:0] seconds;
  logic [5:0] minutes;
  logic [4:0] hours;
  logic       pm;
  logic [7:0] sec_bcd;
  logic [7:0] min_bcd;
  logic [7:0] hour_bcd;
  logic       sec_tick;
  logic       day_pulse;

  wall_clock_core #(.TICKS_PER_SEC(T), .CNT_W(3)) dut (
    .CLK100MHZ(CLK100MHZ), .reset(reset), .enable(enable), .mode_12h(mode_12h),
    .inc_min(inc_min), .inc_hour(inc_hour), .seconds(seconds), .minutes(minutes),
    .hours(hours), .pm(pm), .sec_bcd(sec_bcd), .min_bcd(min_bcd),
    .hour_bcd(hour_bcd), .sec_tick(sec_tick), .day_pulse(day_pulse)
  );

  always #5 CLK100MHZ = ~CLK100MHZ;

  typedef struct packed {
    logic [5:0] s;
    logic [5:0] m;
    logic [4:0] h;
    logic       pm;
    logic [7:0] sb;
    logic [7:0] mb;
    logic [7:0] hb;
    logic       st;
    logic       dp;
  } out_t;

  out_t exp_q[$];
  int   checks = 0;
  int   fails  = 0;
  int   tod    = 0;   // reference time as seconds since midnight
  int   presc  = 0;   // reference prescaler phase
  bit   done   = 0;

  function automatic logic [7:0] bcd(input int v);
    return 8'(((v / 10) << 4) | (v % 10));
  endfunction

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  // Drive one cycle of inputs, predict the outcome of the coming edge,
  // then return just after that edge.
  task automatic step(input logic r, input logic e, input logic md,
                      input logic im, input logic ih);
    int   h, m, dh;
    bit   tk, dy;
    out_t x;
    reset = r; enable = e; mode_12h = md; inc_min = im; inc_hour = ih;
    tk = 0; dy = 0;
    if (r) begin
      tod = 0; presc = 0;
    end else if (im || ih) begin
      h = tod / 3600; m = (tod / 60) % 60;
      if (im) m = (m + 1) % 60;
      if (ih) h = (h + 1) % 24;
      tod = h * 3600 + m * 60;
      presc = 0;
    end else if (e) begin
      if (presc == T - 1) begin
        presc = 0;
        tod = (tod + 1) % 86400;
        tk = 1;
        dy = (tod == 0);
      end else begin
        presc++;
      end
    end
    h  = tod / 3600;
    dh = !md ? h : ((h % 12 == 0) ? 12 : h % 12);
    x.s  = 6'(tod % 60);
    x.m  = 6'((tod / 60) % 60);
    x.h  = 5'(dh);
    x.pm = (h >= 12);
    x.sb = bcd(tod % 60);
    x.mb = bcd((tod / 60) % 60);
    x.hb = bcd(dh);
    x.st = tk;
    x.dp = dy;
    exp_q.push_back(x);
    @(posedge CLK100MHZ);
    #2;
  endtask

  // Monitor: every edge produces an output set; compare against the queue.
  initial begin
    out_t a, x;
    while (!done) begin
      @(posedge CLK100MHZ);
      #1;
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        a = {seconds, minutes, hours, pm, sec_bcd, min_bcd, hour_bcd, sec_tick, day_pulse};
        checks++;
        if (a !== x) begin
          fails++;
          $display("FAIL outputs at %0t actual s=%0d m=%0d h=%0d pm=%0b sb=%h mb=%h hb=%h st=%0b dp=%0b required s=%0d m=%0d h=%0d pm=%0b sb=%h mb=%h hb=%h st=%0b dp=%0b",
                   $time, a.s, a.m, a.h, a.pm, a.sb, a.mb, a.hb, a.st, a.dp,
                   x.s, x.m, x.h, x.pm, x.sb, x.mb, x.hb, x.st, x.dp);
        end
      end
    end
  end

  int tgt_h[5]  = '{0, 11, 12, 13, 23};
  int disp_h[5] = '{12, 11, 12, 1, 11};
  int pm_h[5]   = '{0, 0, 1, 1, 1};
  int bcd_h[5]  = '{'h12, 'h11, 'h12, 'h01, 'h11};

  initial begin
    int hold, mb;
    @(posedge CLK100MHZ);
    #2;

    // Reset values
    step(1, 0, 0, 0, 0);
    step(1, 1, 0, 1, 1);
    chk("reset_sec", seconds, 0);
    chk("reset_hours", hours, 0);
    chk("reset_tick", sec_tick, 0);

    // Free run: tick every 4th cycle
    for (int i = 1; i <= 12; i++) begin
      step(0, 1, 0, 0, 0);
      chk("tick_phase", sec_tick, (i % 4 == 0) ? 1 : 0);
    end
    chk("run_sec", seconds, 3);
    chk("run_sec_bcd", sec_bcd, 'h03);

    // Set 23:59:00, then count to 23:59:59
    for (int i = 0; i < 30 && tod / 3600 != 23; i++) step(0, 0, 0, 0, 1);
    for (int i = 0; i < 70 && (tod / 60) % 60 != 59; i++) step(0, 0, 0, 1, 0);
    for (int i = 0; i < 300 && tod % 60 != 59; i++) step(0, 1, 0, 0, 0);
    chk("pre_day_hours", hours, 23);
    chk("pre_day_pm", pm, 1);
    chk("pre_day_sec", seconds, 59);
    for (int i = 0; i < T; i++) step(0, 1, 0, 0, 0);
    chk("day_tick", sec_tick, 1);
    chk("day_pulse", day_pulse, 1);
    chk("day_hours", hours, 0);
    chk("day_min", minutes, 0);
    chk("day_pm", pm, 0);
    step(0, 1, 0, 0, 0);
    chk("day_pulse_once", day_pulse, 0);

    // 12 h display mapping
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < 30 && tod / 3600 != tgt_h[k]; i++) step(0, 0, 1, 0, 1);
      step(0, 0, 1, 0, 0);
      chk("h12_hours", hours, disp_h[k]);
      chk("h12_pm", pm, pm_h[k]);
      chk("h12_bcd", hour_bcd, bcd_h[k]);
    end

    // 10:59:30 then inc_min: no carry, prescaler restarts
    for (int i = 0; i < 30 && tod / 3600 != 10; i++) step(0, 0, 0, 0, 1);
    for (int i = 0; i < 70 && (tod / 60) % 60 != 59; i++) step(0, 0, 0, 1, 0);
    for (int i = 0; i < 300 && tod % 60 != 30; i++) step(0, 1, 0, 0, 0);
    chk("set_sec30", seconds, 30);
    step(0, 1, 0, 1, 0);
    chk("incmin_hours", hours, 10);
    chk("incmin_min", minutes, 0);
    chk("incmin_sec", seconds, 0);
    for (int i = 1; i <= T; i++) begin
      step(0, 1, 0, 0, 0);
      chk("incmin_tick_gap", sec_tick, (i == T) ? 1 : 0);
    end

    // inc_hour + inc_min at 23:xx on a terminal count
    for (int i = 0; i < 30 && tod / 3600 != 23; i++) step(0, 0, 0, 0, 1);
    for (int i = 0; i < 10 && presc != T - 1; i++) step(0, 1, 0, 0, 0);
    mb = ((tod / 60) % 60 + 1) % 60;
    step(0, 1, 0, 1, 1);
    chk("both_hours", hours, 0);
    chk("both_min", minutes, mb);
    chk("both_sec", seconds, 0);
    chk("both_no_tick", sec_tick, 0);
    chk("both_no_day", day_pulse, 0);

    // Pause mid-count, then reset while running
    for (int i = 0; i < 6; i++) step(0, 1, 0, 0, 0);
    hold = seconds;
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 0, 0, 0);
      chk("pause_sec", seconds, hold);
      chk("pause_tick", sec_tick, 0);
    end
    for (int i = 0; i < 7; i++) step(0, 1, 0, 0, 0);
    step(1, 1, 1, 0, 0);
    chk("rst_run_sec", seconds, 0);
    chk("rst_run_hours12", hours, 12);
    chk("rst_run_hbcd", hour_bcd, 'h12);
    chk("rst_run_pm", pm, 0);

    // Randomized traffic against the reference model
    begin
      logic r, e, md, im, ih;
      md = 0;
      for (int i = 0; i < 600; i++) begin
        r  = ($urandom_range(0, 199) == 0);
        e  = ($urandom_range(0, 99) < 85);
        im = ($urandom_range(0, 99) < 4);
        ih = ($urandom_range(0, 99) < 6);
        if ($urandom_range(0, 99) < 10) md = ~md;
        step(r, e, md, im, ih);
      end
    end

    step(0, 0, 0, 0, 0);
    @(posedge CLK100MHZ);
    #2;
    chk("queue_drained", exp_q.size(), 0);
    done = 1;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/wall_clock_core.md
Name: wall_clock_core

Overview:
- Self-timed time-of-day counter for the board clock domain; replaces the external 1 s toggle and the fixed 24 h counter.
- Generates its own 1 Hz tick from CLK100MHZ with a parametrised prescaler and keeps hours, minutes and seconds.
- Supports 12/24 h display, pause, and button-driven time setting.
- Provides binary and BCD outputs for the seven-segment driver, and an end-of-day pulse.

Parameters:
- TICKS_PER_SEC, 100000000: CLK100MHZ cycles per second; must be ≥2 (benches use 4).
- CNT_W, 27: prescaler width; must satisfy 2^CNT_W ≥ TICKS_PER_SEC.

Ports:
- CLK100MHZ  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- enable  in  1  1 = time runs; 0 = prescaler and counters hold.
- mode_12h  in  1  0 = 24 h display; 1 = 12 h display.
- inc_min  in  1  single-cycle pulse (debounced upstream); advances minutes.
- inc_hour  in  1  single-cycle pulse (debounced upstream); advances hours.
- seconds  out  6  0..59 binary.
- minutes  out  6  0..59 binary.
- hours  out  5  displayed hour, binary: 0..23 (24 h) or 1..12 (12 h).
- pm  out  1  1 when internal hour is ≥12, in either mode.
- sec_bcd  out  8  seconds as BCD, tens in [7:4], units in [3:0].
- min_bcd  out  8  minutes as BCD.
- hour_bcd  out  8  displayed hours as BCD.
- sec_tick  out  1  one-cycle pulse on each seconds advance.
- day_pulse  out  1  one-cycle pulse on the 23:59:59 → 00:00:00 rollover by tick.

Behaviour:
- Reset: prescaler=0 and internal time 00:00:00. Outputs take these values on the first edge with reset high and hold while reset is high:
  - seconds=0, minutes=0, pm=0, sec_tick=0, day_pulse=0.
  - hours=0 in 24 h mode; hours=12 in 12 h mode.
  - BCD outputs match the binary outputs.
- Reset has priority over every other input.
- Prescaler:
  - When enable=1 it counts 0..TICKS_PER_SEC-1.
  - On the edge where it equals TICKS_PER_SEC-1, it wraps to 0 and a tick occurs on that same edge.
  - When enable=0 it holds its value; no ticks occur.
- Tick:
  - seconds+1. At 59, seconds→0 and minutes+1.
  - Minutes at 59 → 0 with hour+1. Internal hour at 23 → 0.
  - All fields update on the same edge.
  - sec_tick is registered high for exactly the cycle in which the new value is visible.
- day_pulse: high in the same cycle as sec_tick when the new time is 00:00:00 reached by tick. Set actions never assert it.
- inc_min: minutes = (minutes+1) mod 60 with no carry into hours; seconds→0; prescaler→0.
- inc_hour: internal hour = (hour+1) mod 24; seconds→0; prescaler→0. Minutes are unchanged.
- inc_min and inc_hour in the same cycle: both fields advance independently, as above.
- Any inc in a cycle suppresses that cycle's tick: no sec_tick, no day_pulse.
- inc_min and inc_hour are honoured regardless of enable.
- Time is always held internally as 0..23. Display mapping is combinational on registered state; the outputs themselves are registered:
  - 24 h mode: hours = internal hour.
  - 12 h mode: internal 0→12, 1..12 unchanged, 13..23 → 1..11.
- mode_12h may change at any time. It affects only hours and hour_bcd, from the next edge; the counting state is unaffected.
- BCD outputs: tens = value/10, units = value mod 10. They are registered together with the binary outputs, so both are always coherent in the same cycle.
- Latency:
  - Inputs are sampled on edge N; outputs reflect the effect after edge N.
  - No other pipeline delay.

Test Plan:
- Reset, then enable=1 with TICKS_PER_SEC=4:
  - sec_tick on cycles 4, 8, 12, …
  - seconds 1, 2, 3, …
  - sec_bcd=8'h01, 8'h02, …
- Run to 23:59:59, then one tick:
  - Time becomes 00:00:00.
  - sec_tick=1 and day_pulse=1 for one cycle.
  - pm goes 1→0.
- mode_12h=1, stepping internal hour 0, 11, 12, 13, 23:
  - hours = 12, 11, 12, 1, 11.
  - pm = 0, 0, 1, 1, 1.
  - hour_bcd = 8'h12, 8'h11, 8'h12, 8'h01, 8'h11.
- At 10:59:30, pulse inc_min: time becomes 10:00:00 (no carry into hours), and the next tick comes 4 cycles later.
- inc_hour at 23:xx together with inc_min, coincident with a prescaler terminal count:
  - Hours→0 and minutes+1 mod 60.
  - No sec_tick and no day_pulse that cycle.
- enable=0 mid-count for 10 cycles: time and prescaler hold. Then assert reset while enable=1: all outputs go to their reset values after 1 edge.
